// File: rtl/uart_tx_arbiter_pkg.sv
// ============================================================================
//  Module      : uart_tx_arbiter_pkg
//  Description : Shared state encodings, defaults and helpers for the
//                uart_tx round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_arbiter_pkg;

  localparam int c_N_REQ_DEFAULT = 4;
  localparam int c_DW            = 8;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_START = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;

  // Successor of idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) return 32'd0;
    return idx + 32'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
//  Module      : uart_rr_picker
//  Description : Combinational round-robin picker; first set request at or
//                after the pointer wins, wrapping modulo N_REQ.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_picker #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_winner_oh,
  output logic [PW-1:0]    o_winner_idx,
  output logic             o_any
);

  int   w_pos;
  logic w_found;

  always_comb begin
    o_winner_oh  = '0;
    o_winner_idx = '0;
    w_found      = 1'b0;
    w_pos        = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N_REQ) w_pos = w_pos - N_REQ;
      if (!w_found && i_req[w_pos]) begin
        w_found             = 1'b1;
        o_winner_oh[w_pos]  = 1'b1;
        o_winner_idx        = PW'(w_pos);
      end
    end
  end

  assign o_any = |i_req;

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin sharing of one uart_tx among N_REQ byte
//                producers. Define UART_ARB_LOCK_EN to add the lock input.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = c_N_REQ_DEFAULT,
  parameter int DW    = c_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] data_in,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    grant,
  output logic                busy,
  output logic [DW-1:0]       tx_data,
  output logic                tx_start,
  input  logic                tx_ready
`ifdef UART_ARB_LOCK_EN
  ,
  input  logic [N_REQ-1:0]    lock
`endif
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [1:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic [N_REQ-1:0] r_ack;
  logic [N_REQ-1:0] r_grant;
  logic [DW-1:0]    r_tx_data;
  logic             r_tx_start;
`ifdef UART_ARB_LOCK_EN
  logic [PW-1:0]    r_owner;
`endif

  logic [N_REQ-1:0] w_win_oh;
  logic [PW-1:0]    w_win_idx;
  logic             w_any;
  logic [DW-1:0]    w_bytes [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign w_bytes[gi] = data_in[gi*DW +: DW];
  end

  uart_rr_picker #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_picker (
    .i_req        (req),
    .i_ptr        (r_ptr),
    .o_winner_oh  (w_win_oh),
    .o_winner_idx (w_win_idx),
    .o_any        (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_ST_IDLE;
      r_ptr      <= '0;
      r_ack      <= '0;
      r_grant    <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
`ifdef UART_ARB_LOCK_EN
      r_owner    <= '0;
`endif
    end else begin
      r_ack <= '0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_any) begin
            r_tx_data  <= w_bytes[w_win_idx];
            r_grant    <= w_win_oh;
            r_ack      <= w_win_oh;
            r_tx_start <= 1'b1;
            r_ptr      <= PW'(rr_next(32'(w_win_idx), N_REQ));
`ifdef UART_ARB_LOCK_EN
            r_owner    <= w_win_idx;
`endif
            r_state    <= c_ST_START;
          end
        end
        // uart_tx drops ready once it has latched start&data.
        c_ST_START: begin
          if (!tx_ready) begin
            r_tx_start <= 1'b0;
            r_state    <= c_ST_WAIT;
          end
        end
        c_ST_WAIT: begin
          if (tx_ready) begin
            r_grant <= '0;
            r_state <= c_ST_IDLE;
`ifdef UART_ARB_LOCK_EN
            if (lock[r_owner]) r_ptr <= r_owner;
`endif
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_grant    <= '0;
          r_state    <= c_ST_IDLE;
        end
      endcase
    end
  end

  assign ack      = r_ack;
  assign grant    = r_grant;
  assign busy     = (r_state != c_ST_IDLE);
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter with a uart_tx model,
//                queue-based producers and an abstract arbitration model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   data_in;
  logic [N-1:0]      ack;
  logic [N-1:0]      grant;
  logic              busy;
  logic [DW-1:0]     tx_data;
  logic              tx_start;
  logic              tx_ready;
`ifdef UART_ARB_LOCK_EN
  logic [N-1:0]      lock;
`endif

  uart_tx_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .data_in  (data_in),
    .ack      (ack),
    .grant    (grant),
    .busy     (busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready)
`ifdef UART_ARB_LOCK_EN
    ,
    .lock     (lock)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pend [N][$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int         ack_log[$];
  logic [7:0] exp_seq[$];
  int         exp_ack[$];

  // Reference model state
  logic            s_rst;
  logic [N-1:0]    s_req;
  logic [N-1:0]    s_lock;
  logic [N*DW-1:0] s_data;
  logic            s_rdy;
  int              m_phase;
  int              m_ptr;
  int              m_owner;
  logic [7:0]      m_byte;
  logic [N-1:0]    m_oh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Producers: each presents the head of its queue and advances on ack.
  initial begin
    req     = '0;
    data_in = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i] && pend[i].size() > 0) void'(pend[i].pop_front());
        if (pend[i].size() > 0) begin
          req[i]              = 1'b1;
          data_in[i*DW +: DW] = pend[i][0];
        end else begin
          req[i]              = 1'b0;
          data_in[i*DW +: DW] = 8'($urandom);
        end
      end
    end
  end

  // uart_tx model and scoreboard monitor: pops on every accepted frame.
  initial begin
    int cnt;
    cnt      = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_ready && tx_start) begin
        tx_log.push_back(tx_data);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got byte %0h expected none at %0t", tx_data, $time);
        end else begin
          chk("sb_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
        tx_ready = 1'b0;
        cnt      = $urandom_range(8, 3);
      end else if (!tx_ready) begin
        cnt--;
        if (cnt == 0) tx_ready = 1'b1;
      end
    end
  end

  // Abstract model: offer -> accepted (ready low) -> finished (ready high).
  initial begin
    m_phase = 0;
    m_ptr   = 0;
    m_owner = 0;
    m_byte  = '0;
    forever begin
      @(posedge clk);
      s_rst  = rst;
      s_req  = req;
      s_data = data_in;
      s_rdy  = tx_ready;
`ifdef UART_ARB_LOCK_EN
      s_lock = lock;
`else
      s_lock = '0;
`endif
      #1;
      for (int i = 0; i < N; i++) if (ack[i]) ack_log.push_back(i);
      m_oh = '0;
      m_oh[m_owner] = 1'b1;
      if (s_rst) begin
        chk("rst_ack", 32'(ack), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(tx_start), 0);
        chk("rst_data", 32'(tx_data), 0);
        m_phase = 0;
        m_ptr   = 0;
      end else if (m_phase == 0) begin
        if (s_req != '0) begin
          m_owner = pick(s_req, m_ptr);
          m_oh    = '0;
          m_oh[m_owner] = 1'b1;
          m_byte  = s_data[m_owner*DW +: DW];
          chk("arb_ack", 32'(ack), 32'(m_oh));
          chk("arb_grant", 32'(grant), 32'(m_oh));
          chk("arb_start", 32'(tx_start), 1);
          chk("arb_data", 32'(tx_data), 32'(m_byte));
          chk("arb_busy", 32'(busy), 1);
          exp_q.push_back(m_byte);
          m_ptr   = (m_owner + 1) % N;
          m_phase = 1;
        end else begin
          chk("idle_ack", 32'(ack), 0);
          chk("idle_grant", 32'(grant), 0);
          chk("idle_busy", 32'(busy), 0);
          chk("idle_start", 32'(tx_start), 0);
        end
      end else if (m_phase == 1) begin
        chk("st_ack", 32'(ack), 0);
        chk("st_grant", 32'(grant), 32'(m_oh));
        chk("st_data", 32'(tx_data), 32'(m_byte));
        if (!s_rdy) begin
          chk("acc_start", 32'(tx_start), 0);
          m_phase = 2;
        end else begin
          chk("st_start", 32'(tx_start), 1);
        end
      end else begin
        chk("wt_start", 32'(tx_start), 0);
        chk("wt_ack", 32'(ack), 0);
        if (s_rdy) begin
          chk("end_grant", 32'(grant), 0);
          chk("end_busy", 32'(busy), 0);
          if (s_lock[m_owner]) m_ptr = m_owner;
          m_phase = 0;
        end else begin
          chk("wt_grant", 32'(grant), 32'(m_oh));
          chk("wt_busy", 32'(busy), 1);
        end
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i].delete();
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int  t;
    bit  done;
    t    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      t++;
      done = 1'b1;
      for (int i = 0; i < N; i++) if (pend[i].size() != 0) done = 1'b0;
      if (busy || !tx_ready || req != '0) done = 1'b0;
      if (t > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain_timeout: got busy %0b expected idle at %0t", busy, $time);
        done = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_tx(input string name);
    chk({name, "_len"}, 32'(tx_log.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < tx_log.size(); i++)
      chk(name, 32'(tx_log[i]), 32'(exp_seq[i]));
  endtask

  task automatic compare_ack(input string name);
    chk({name, "_len"}, 32'(ack_log.size()), 32'(exp_ack.size()));
    for (int i = 0; i < exp_ack.size() && i < ack_log.size(); i++)
      chk(name, 32'(ack_log[i]), 32'(exp_ack[i]));
  endtask

  initial begin
    int t;
    rst = 1'b1;
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte from requester 0
    tx_log.delete(); ack_log.delete();
    pend[0].push_back(8'h48);
    wait_drain();
    exp_seq = '{8'h48};  compare_tx("t1_tx");
    exp_ack = '{0};      compare_ack("t1_ack");

    // All four requesting, wrap back to requester 0
    do_reset(2);
    tx_log.delete(); ack_log.delete();
    pend[0].push_back(8'h41); pend[0].push_back(8'h41);
    pend[1].push_back(8'h42);
    pend[2].push_back(8'h43);
    pend[3].push_back(8'h44);
    wait_drain();
    exp_seq = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h41};  compare_tx("t2_tx");
    exp_ack = '{0, 1, 2, 3, 0};                      compare_ack("t2_ack");

    // Sparse requests 1010 from ptr 0
    do_reset(2);
    tx_log.delete(); ack_log.delete();
    pend[1].push_back(8'h51); pend[1].push_back(8'h52);
    pend[3].push_back(8'h53);
    wait_drain();
    exp_seq = '{8'h51, 8'h53, 8'h52};  compare_tx("t3_tx");
    exp_ack = '{1, 3, 1};              compare_ack("t3_ack");

    // Requester drops req and scrambles data after ack
    tx_log.delete(); ack_log.delete();
    pend[2].push_back(8'h77);
    wait_drain();
    exp_seq = '{8'h77};  compare_tx("t5_tx");

    // Reset while the second frame is in flight
    do_reset(2);
    tx_log.delete(); ack_log.delete();
    pend[0].push_back(8'hA1); pend[0].push_back(8'hA2);
    pend[1].push_back(8'hB1);
    t = 0;
    while (!(ack_log.size() >= 2 && busy && !tx_ready) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("t4_reach_wait", 32'(t < 500), 1);
    do_reset(2);
    t = 0;
    while (!tx_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    ack_log.delete();
    pend[1].push_back(8'hC1);
    pend[2].push_back(8'hC2);
    wait_drain();
    exp_ack = '{1, 2};  compare_ack("t4_ack");

    // String from requester 0 against one from requester 1
    do_reset(2);
    tx_log.delete(); ack_log.delete();
`ifdef UART_ARB_LOCK_EN
    lock = 4'b0001;
`endif
    pend[0] = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h21, 8'h2E, 8'h2E, 8'h2E};
    pend[1] = '{8'h31, 8'h32};
    wait_drain();
`ifdef UART_ARB_LOCK_EN
    lock = '0;
    exp_seq = '{8'h48, 8'h6F, 8'h6C, 8'h61, 8'h21, 8'h2E, 8'h2E, 8'h2E, 8'h31, 8'h32};
`else
    exp_seq = '{8'h48, 8'h31, 8'h6F, 8'h32, 8'h6C, 8'h61, 8'h21, 8'h2E, 8'h2E, 8'h2E};
`endif
    compare_tx("t6_tx");

    // Randomized traffic checked by the model and scoreboard
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if (pend[i].size() < 3 && $urandom_range(3, 0) == 0)
          pend[i].push_back(8'($urandom));
`ifdef UART_ARB_LOCK_EN
      if (c % 40 == 0) lock = 4'($urandom);
`endif
    end
`ifdef UART_ARB_LOCK_EN
    lock = '0;
`endif
    wait_drain();
    chk("sb_leftover", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx serial transmitter among N_REQ independent byte producers (string senders, debug taps, status reporters).
- Arbitrates round-robin, latches the winner's byte, drives the transmitter's start/data pair and waits for the frame to finish.
- Sits between the producers and uart_tx; all producers see a simple req/ack byte handshake.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 8, data width per requester (fixed 8 for uart_tx; kept parametric for the package).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, synchronous, active-high.
- req  in  N_REQ  per-requester "byte pending"; level, held until ack.
- data_in  in  N_REQ*DW  flattened bytes; requester i occupies bits [i*DW +: DW].
- ack  out  N_REQ  one-cycle pulse: byte of requester i captured.
- grant  out  N_REQ  one-hot owner of the transmitter; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- tx_data  out  DW  byte to uart_tx data input (registered).
- tx_start  out  1  to uart_tx start.
- tx_ready  in  1  from uart_tx ready (1 = idle, 0 = shifting a frame).

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; ack=0, grant=0, busy=0, tx_start=0, tx_data=0x00; round-robin pointer=0, so requester 0 has top priority. Applies mid-frame too: tx_start drops on the next edge. The uart_tx frame in flight is not aborted by this block.
- Round-robin: search starts at ptr, wraps modulo N_REQ. First set req bit wins. After a grant to i, ptr=(i+1) mod N_REQ, with wrap from N_REQ-1 to 0.
- IDLE:
  - If |req at edge T: latch winner g. At T+1: tx_data=data_in[g], grant=onehot(g), ack[g]=1 for exactly one cycle, tx_start=1, state=START.
  - Otherwise stay in IDLE.
- START: hold tx_start=1 and tx_data stable.
  - When tx_ready==0 (frame accepted): tx_start=0 next cycle, state=WAIT.
  - Stay in START while tx_ready==1. uart_tx latches on start&ready, so ready falls within 1-2 cycles.
- WAIT: tx_start=0. When tx_ready==1: state=IDLE, grant=0, busy=0.
- Requester contract: drop req (or present the next byte) in the cycle after ack. A req still high then is treated as a new byte.
  - Requester sending a string: advance its character counter on ack and keep req high.
- Latency: req seen at T -> tx_start at T+1. Minimum gap between frames from different requesters = 1 IDLE cycle after ready rises.
- req deasserted after ack: no effect; the latched byte is still sent.
- data_in changes after ack: ignored.
- req bits of non-owners during START/WAIT: ignored until IDLE.
- Exactly one ack bit ever high. ack and grant are never set for a requester whose req was low at the arbitration edge.

Optional Feature:
UART_ARB_LOCK_EN
- Defined: adds input lock[N_REQ]. If lock[g] is high when WAIT exits, the arbiter returns to IDLE with ptr forced to g. g therefore wins again if req[g] is high, so a whole string goes out uninterleaved.
  - Lock ends when lock[g] goes low.
  - If req[g] is low while lock[g] is high, the lock is released and normal round-robin resumes.
- Undefined: no lock port; pure per-byte round-robin.

Decomposition:
- Shared package/header (alongside baudgen.vh): state encodings IDLE=0, START=1, WAIT=2, default N_REQ, DW=8.
- Sub-module uart_rr_picker: combinational round-robin picker. Inputs req and ptr; outputs one-hot winner, winner index and any flag.
- The top holds the FSM, ptr and the data/ack/grant registers.

Test Plan:
1. Reset then req=4'b0001, data_in[0]=0x48: at T+1 ack=0001, grant=0001, tx_start=1, tx_data=0x48. tx_start falls after tx_ready drops. Serial line shows 'H' at 115200. busy returns 0 after the stop bit.
2. req=4'b1111 held, bytes 0x41..0x44 re-presented after each ack: frames are sent in order 0x41, 0x42, 0x43, 0x44, 0x41 (wrap check). Exactly one ack per frame.
3. req=4'b1010 with ptr=0: requester 1 served first, then 3, then 1.
4. Assert rst during WAIT of frame 2: at the next edge grant=0, tx_start=0, busy=0, ptr=0. With req=4'b0110 afterwards, the next grant goes to requester 1.
5. Requester 2 drops req the cycle after ack and changes data_in: the transmitted byte still equals the latched value.
6. With UART_ARB_LOCK_EN, lock[0]=1, req=4'b0011: all 8 bytes "Hola!..." from requester 0 are sent contiguously before requester 1 gets a frame. Without the macro, the two requesters alternate.
